// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared UART definitions: receiver/transmitter FSM state encoding,
//            default frame parameters and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Frame defaults: 8 data bits, 16x oversampling, one stop bit.
  localparam int c_DBITS_DEF   = 8;
  localparam int c_SB_TICK_DEF = 16;
  localparam int c_OS_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Bits needed to count 0 .. max_val-1 (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Receiver-side bundle: serial line and oversample strobe in,
//            received word, completion pulse and framing error out.
// Ports    : rx, s_tick (master -> slave); rx_dout, rx_done_tick,
//            frame_err (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DBITS = c_DBITS_DEF
) ();

  logic             rx;
  logic             s_tick;
  logic [DBITS-1:0] rx_dout;
  logic             rx_done_tick;
  logic             frame_err;

  modport master (
    output rx, s_tick,
    input  rx_dout, rx_done_tick, frame_err
  );

  modport slave (
    input  rx, s_tick,
    output rx_dout, rx_done_tick, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous input bit.
// Ports    : clk, reset (async, active low), i_d (async input),
//            o_q (synchronized output). RST_VAL sets both flops on reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling UART receiver. Detects the start bit on a falling
//            edge of the synchronized line, samples each bit at its middle
//            using an external oversample strobe, and reports the word with
//            a one-cycle completion pulse and a stop-bit framing error.
// Ports    : clk, reset (async, active low), bus (uart_rx_if.slave:
//            rx, s_tick in; rx_dout, rx_done_tick, frame_err out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBITS   = c_DBITS_DEF,
  parameter int SB_TICK = c_SB_TICK_DEF,
  parameter int OS      = c_OS_DEF
) (
  input  wire logic  clk,
  input  wire logic  reset,
  uart_rx_if.slave   bus
);

  localparam int c_SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int c_SW   = cnt_width(c_SMAX);
  localparam int c_NW   = cnt_width(DBITS);

  localparam logic [c_SW-1:0] c_S_HALF = c_SW'(OS / 2 - 1);
  localparam logic [c_SW-1:0] c_S_BIT  = c_SW'(OS - 1);
  localparam logic [c_SW-1:0] c_S_STOP = c_SW'(SB_TICK - 1);
  localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DBITS - 1);

  uart_state_t      r_state, w_state_nxt;
  logic [c_SW-1:0]  r_s, w_s_nxt;
  logic [c_NW-1:0]  r_n, w_n_nxt;
  logic [DBITS-1:0] r_b, w_b_nxt;
  logic [DBITS-1:0] r_dout, w_dout_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             r_rx_prev;
  logic             w_rx_s;
  logic             w_fall;
  logic [DBITS:0]   w_cat;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  // Start is an edge, not a level: after a break the line must return high
  // and fall again before a new frame begins.
  assign w_fall = r_rx_prev & ~w_rx_s;
  // LSB arrives first, so new bits enter at the top and shift down.
  assign w_cat  = {w_rx_s, r_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_n       <= '0;
      r_b       <= '0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_rx_prev <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_n       <= w_n_nxt;
      r_b       <= w_b_nxt;
      r_dout    <= w_dout_nxt;
      r_done    <= w_done_nxt;
      r_ferr    <= w_ferr_nxt;
      r_rx_prev <= w_rx_s;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
          w_n_nxt     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (r_s == c_S_HALF) begin
            // Middle of the start bit: still low means a real frame.
            w_state_nxt = w_rx_s ? IDLE : DATA;
            w_s_nxt     = '0;
            w_n_nxt     = '0;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (r_s == c_S_BIT) begin
            w_s_nxt = '0;
            w_b_nxt = w_cat[DBITS:1];
            if (r_n == c_N_LAST) begin
              w_state_nxt = STOP;
              w_n_nxt     = '0;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (r_s == c_S_STOP) begin
            w_dout_nxt  = r_b;
            w_done_nxt  = 1'b1;
            w_ferr_nxt  = ~w_rx_s;
            w_state_nxt = IDLE;
            w_s_nxt     = '0;
            w_n_nxt     = '0;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_s_nxt     = '0;
        w_n_nxt     = '0;
      end
    endcase
  end

  assign bus.rx_dout      = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_ferr;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBITS, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, oversample ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter OS, default 16, oversample ticks per bit; legal values are even and ≥ 4.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 s_tick  input  1  one-clk-wide oversample strobe, OS per bit time, from the team's baud timer.
REQ-008 rx_dout  output  DBITS  last received data word, LSB first on the line.
REQ-009 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-010 frame_err  output  1  valid only with rx_done_tick; high when the sampled stop bit is 0.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer, reset value 1; all logic uses the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-013 Registers: tick counter s (log2 of max(OS, SB_TICK) bits), bit counter n (log2 of DBITS bits), and shift register b (DBITS bits).
REQ-014 IDLE: when rx_s = 0, go to START and clear s; s_tick is not required for this transition.
REQ-015 START: on each s_tick, increment s; when s_tick arrives with s = OS/2-1, check rx_s.
REQ-016 START check: rx_s = 0 → go to DATA with s = 0 and n = 0; rx_s = 1 (glitch) → return to IDLE with no output pulse.
REQ-017 DATA: on each s_tick, increment s; when s_tick arrives with s = OS-1, clear s and shift: b = {rx_s, b[DBITS-1:1]}.
REQ-018 DATA exit: when that shift happens with n = DBITS-1, go to STOP; otherwise increment n.
REQ-019 STOP: on each s_tick, increment s; when s_tick arrives with s = SB_TICK-1, sample rx_s.
REQ-020 STOP completion, in the same clk edge: load rx_dout with b, assert rx_done_tick for exactly one cycle, set frame_err to the inverse of the stop sample, and go to IDLE.
REQ-021 rx_done_tick and frame_err SHALL be registered and low in all other cycles.
REQ-022 rx_dout SHALL hold its value until the next completion.
REQ-023 s_tick SHALL be ignored in IDLE.
REQ-024 A falling edge of rx_s outside IDLE SHALL have no effect.
REQ-025 Back-to-back frames SHALL be received with zero idle bits between the stop bit and the next start bit.
REQ-026 A frame_err frame SHALL still update rx_dout.
REQ-027 A break condition (rx held low) SHALL yield a frame_err completion, then re-enter START only after rx_s returns high and falls again.
REQ-028 Counters SHALL never wrap; each counter is cleared at every state transition.

Reset
REQ-029 While reset = 0, regardless of clk: state = IDLE, s = 0, n = 0, b = 0, rx_dout = 0, rx_done_tick = 0, frame_err = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-031 Reception SHALL resume on the first falling edge of rx_s after reset is released.

Structure
REQ-032 State encodings and the defaults for DBITS, OS and SB_TICK SHALL live in the shared UART package, for reuse by uart_tx.
REQ-033 The synchronizer SHALL be a separate sub-module, sync_2ff, with reset value as a parameter.
REQ-034 Tick generation SHALL stay external, in the existing timer block; uart_rx contains no baud divider.

Verification
Common setup: s_tick every 4 clk, OS = 16, DBITS = 8, SB_TICK = 16.
REQ-035 Send frame 0xA5 with stop bit 1 → one rx_done_tick, rx_dout = 0xA5, frame_err = 0; no pulse before the stop-sample tick.
REQ-036 Drive rx low for 5 ticks, then high → FSM returns to IDLE; no rx_done_tick; rx_dout unchanged.
REQ-037 Send 0x3C with stop bit 0 → rx_done_tick with frame_err = 1 and rx_dout = 0x3C.
REQ-038 Send 0x00 immediately followed by 0xFF, zero idle bits between → two pulses, rx_dout = 0x00 then 0xFF, frame_err = 0 for both.
REQ-039 Assert reset during data bit 3 of 0x81 → all outputs 0 immediately; after release, a full frame 0x5A → rx_dout = 0x5A, one pulse.
REQ-040 Random bytes at DBITS = 7 and SB_TICK = 32 → every byte matches and no spurious pulses occur.
